// File: rtl/riscv_pkg.sv
// Shared RV32I encoder types and constants.
// ENC_LI_EXPAND_EN adds the S_LO state used by the LI pseudo-op expansion.
package riscv_pkg;

  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_I  = 3'd1,
    FMT_S  = 3'd2,
    FMT_B  = 3'd3,
    FMT_U  = 3'd4,
    FMT_J  = 3'd5,
    FMT_LI = 3'd6
  } enc_fmt_t;

`ifdef ENC_LI_EXPAND_EN
  typedef enum logic {S_IDLE, S_LO} enc_state_t;
`else
  typedef enum logic {S_IDLE} enc_state_t;
`endif

  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;
  localparam int IMM21_MIN = -(1 << 20);
  localparam int IMM21_MAX = (1 << 20) - 2;

  function automatic logic in_range(input logic [31:0] v, input int lo, input int hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Descriptor-in / instruction-out bus of the encoder, plus its control and status.
interface instr_encoder_if #(parameter int AW = 32) ();
  import riscv_pkg::*;

  logic          start;
  logic [AW-1:0] base_addr;
  logic          in_valid;
  logic          in_ready;
  enc_fmt_t      in_fmt;
  logic [6:0]    in_opcode;
  logic [4:0]    in_rd;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic [2:0]    in_funct3;
  logic [6:0]    in_funct7;
  logic [31:0]   in_imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          err;
  logic [AW-1:0] err_addr;

  modport master (
    output start, base_addr, in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, err, err_addr
  );

  modport slave (
    input  start, base_addr, in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, err, err_addr
  );
endinterface

// File: rtl/instr_encoder_imm_pack.sv
// Combinational immediate scatter: places imm bits at their RV32I positions per format
// and reports whether the immediate is encodable.
module enc_imm_pack
  import riscv_pkg::*;
(
  input  enc_fmt_t    fmt_i,
  input  logic [31:0] imm_i,
  output logic [31:0] imm_bits_o,
  output logic        range_ok_o
);

  always_comb begin
    imm_bits_o = '0;
    range_ok_o = 1'b0;
    case (fmt_i)
      FMT_R: range_ok_o = 1'b1;
      // LI shares the I placement; range_ok then selects the single-ADDI form
      FMT_I, FMT_LI: begin
        imm_bits_o = {imm_i[11:0], 20'b0};
        range_ok_o = in_range(imm_i, IMM12_MIN, IMM12_MAX);
      end
      FMT_S: begin
        imm_bits_o = {imm_i[11:5], 13'b0, imm_i[4:0], 7'b0};
        range_ok_o = in_range(imm_i, IMM12_MIN, IMM12_MAX);
      end
      FMT_B: begin
        imm_bits_o = {imm_i[12], imm_i[10:5], 13'b0, imm_i[4:1], imm_i[11], 7'b0};
        range_ok_o = in_range(imm_i, IMM13_MIN, IMM13_MAX) && !imm_i[0];
      end
      FMT_U: begin
        imm_bits_o = {imm_i[31:12], 12'b0};
        range_ok_o = (imm_i[11:0] == 12'b0);
      end
      FMT_J: begin
        imm_bits_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], 12'b0};
        range_ok_o = in_range(imm_i, IMM21_MIN, IMM21_MAX) && !imm_i[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: descriptor -> registered instruction word at sequential addresses.
// ENC_LI_EXPAND_EN enables LI expansion (ADDI, or LUI+ADDI via S_LO); otherwise LI is illegal.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int AW = 32
) (
  input logic            clk,
  input logic            rst_n,
  instr_encoder_if.slave bus
);

  logic [31:0] imm_bits;
  logic        range_ok;

  enc_imm_pack u_imm_pack (
    .fmt_i      (bus.in_fmt),
    .imm_i      (bus.in_imm),
    .imm_bits_o (imm_bits),
    .range_ok_o (range_ok)
  );

  enc_state_t    state_q, state_d;
  logic          out_valid_q;
  logic [31:0]   out_instr_q;
  logic [AW-1:0] out_addr_q;
  logic [AW-1:0] cnt_q;
  logic          err_q;
  logic [AW-1:0] err_addr_q;
`ifdef ENC_LI_EXPAND_EN
  logic [31:0]   lo_q, lo_d;
`endif

  logic          slot_free, in_ready, load, ill;
  logic [31:0]   word_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    slot_free = !out_valid_q || bus.out_ready;
    in_ready  = (state_q == S_IDLE) && slot_free;
    load      = bus.in_valid && in_ready;
    state_d   = state_q;
    word_d    = INSTR_NOP;
    ill       = 1'b0;
`ifdef ENC_LI_EXPAND_EN
    lo_d      = lo_q;
`endif
    case (bus.in_fmt)
      FMT_R: word_d = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd,
                       bus.in_opcode};
      FMT_I: word_d = imm_bits | {12'b0, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
      FMT_S, FMT_B:
        word_d = imm_bits | {7'b0, bus.in_rs2, bus.in_rs1, bus.in_funct3, 5'b0, bus.in_opcode};
      FMT_U, FMT_J:
        word_d = imm_bits | {20'b0, bus.in_rd, bus.in_opcode};
`ifdef ENC_LI_EXPAND_EN
      FMT_LI: begin
        if (range_ok) begin
          word_d = imm_bits | {12'b0, 5'd0, 3'b000, bus.in_rd, OPC_OP_IMM};
        end else begin
          // +0x800 pre-compensates the sign extension of the low 12 bits in the ADDI
          word_d = {20'((bus.in_imm + 32'h800) >> 12), bus.in_rd, OPC_LUI};
          lo_d   = {bus.in_imm[11:0], bus.in_rd, 3'b000, bus.in_rd, OPC_OP_IMM};
          if (load) state_d = S_LO;
        end
      end
`endif
      default: ill = 1'b1;
    endcase
`ifdef ENC_LI_EXPAND_EN
    if (bus.in_fmt != FMT_LI && !range_ok) ill = 1'b1;
`else
    if (!range_ok) ill = 1'b1;
`endif
    if (ill) word_d = INSTR_NOP;
`ifdef ENC_LI_EXPAND_EN
    if (state_q == S_LO) begin
      load    = slot_free;
      word_d  = lo_q;
      ill     = 1'b0;
      if (slot_free) state_d = S_IDLE;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
`ifdef ENC_LI_EXPAND_EN
      lo_q        <= '0;
`endif
    end else begin
`ifdef ENC_LI_EXPAND_EN
      lo_q <= lo_d;
`endif
      // cnt_q is the next free slot; a word already in the output register keeps its address
      if (load) begin
        out_valid_q <= 1'b1;
        out_instr_q <= word_d;
        out_addr_q  <= cnt_q;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (bus.start)  cnt_q <= bus.base_addr & ~AW'(3);
      else if (load)  cnt_q <= cnt_q + AW'(4);
      if (bus.start) begin
        err_q <= 1'b0;
      end else if (load && ill) begin
        err_q <= 1'b1;
        if (!err_q) err_addr_q <= cnt_q;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.err       = err_q;
  assign bus.err_addr  = err_addr_q;

endmodule
